// File: rtl/timer_counter_core.sv
// timer_counter_core: up/down timer counting synchronised edges of a selectable clock source,
// with reload, one-shot/auto-reload, sticky ovf/unf flags and a compare-match pulse.
`timescale 1ns/1ps
module timer_counter_core #(
    parameter int WIDTH       = 16,
    parameter int NCLK        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic [NCLK-1:0]         clk_in,
    input  logic [$clog2(NCLK)-1:0] clk_sel,
    input  logic                    en,
    input  logic                    updown,
    input  logic                    load,
    input  logic                    one_shot,
    input  logic                    reconf,
    input  logic [WIDTH-1:0]        reload_val,
    input  logic [WIDTH-1:0]        cmp_val,
    input  logic                    flag_clr,
    output logic [WIDTH-1:0]        cnt,
    output logic                    ovf_flag,
    output logic                    unf_flag,
    output logic                    cmp_pulse,
    output logic                    done
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [SYNC_STAGES-1:0][NCLK-1:0] sync_q;
    logic [$clog2(NCLK)-1:0]          sel_q;
    logic                             sel_chg_q;
    logic                             edge_q;
    logic                             sel_bit;
    logic                             tick;
    logic [WIDTH-1:0]                 init_val;
    logic [WIDTH-1:0]                 nxt_cnt;
    logic                             evt;
    logic                             term;
    logic                             upd;

    assign sel_bit  = sync_q[SYNC_STAGES-1][sel_q];
    // edge_q still holds the old source's level right after a switch, so mask that cycle
    assign tick     = sel_bit & ~edge_q & ~sel_chg_q;
    assign init_val = load ? reload_val : (updown ? MAX : '0);
    assign evt      = tick & en & ~done & ~reconf;
    assign term     = updown ? (cnt == '0) : (cnt == MAX);
    assign nxt_cnt  = term ? init_val : (updown ? cnt - WIDTH'(1) : cnt + WIDTH'(1));
    assign upd      = evt & ~(term & one_shot);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sync_q    <= '0;
            sel_q     <= '0;
            sel_chg_q <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], clk_in};
            sel_q     <= clk_sel;
            sel_chg_q <= clk_sel != sel_q;
            edge_q    <= sel_bit;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt       <= '0;
            ovf_flag  <= 1'b0;
            unf_flag  <= 1'b0;
            cmp_pulse <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmp_pulse <= upd && (nxt_cnt == cmp_val);
            ovf_flag  <= (evt & term & ~updown) | (ovf_flag & ~flag_clr);
            unf_flag  <= (evt & term & updown) | (unf_flag & ~flag_clr);
            if (reconf) begin
                cnt  <= init_val;
                done <= 1'b0;
            end else if (!en) begin
                done <= 1'b0;
            end else if (upd) begin
                cnt <= nxt_cnt;
            end else if (evt) begin
                done <= 1'b1;
            end
        end
    end
endmodule
